// File: rtl/pim_load_sched.sv
// rtl/pim_load_sched.sv - arbitrated one-hot PIM_load scheduler for a holding-register bank (option macro: PIM_SCHED_FIXED_PRIO_EN)
module pim_load_sched #(
   parameter int N    = 10,
   parameter int NREQ = 4,
   parameter int NREG = 8,
   // Address is wide enough to hold the value NREG itself, so out-of-range
   // targets arrive intact and are reported with addr_err rather than aliasing.
   localparam int AW  = $clog2(NREG + 1),
   localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*N-1:0]  req_data,
   output logic [NREQ-1:0]    ack,
   output logic               addr_err,
   output logic [NREG-1:0]    load_en,
   output logic [N-1:0]       load_data,
   output logic [GW-1:0]      gnt_id,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ACK  = 2'd2
   } state_e;

   state_e            state_q;
   logic [AW-1:0]     addr_q;
   logic [N-1:0]      load_data_q;
   logic [GW-1:0]     gnt_id_q;
   logic [NREG-1:0]   load_en_q;
   logic [NREQ-1:0]   ack_q;
   logic              addr_err_q;
   logic              busy_q;

   logic              win_valid_d;
   logic [GW-1:0]     win_id_d;
   logic [AW-1:0]     win_addr_d;
   logic [N-1:0]      win_data_d;
   logic [NREG-1:0]   load_en_d;
   logic [NREQ-1:0]   ack_d;
   logic              addr_oor_d;

`ifdef PIM_SCHED_FIXED_PRIO_EN
   // Fixed priority: lowest set index wins (scan high to low, last hit sticks).
   always_comb begin
      win_valid_d = 1'b0;
      win_id_d    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_valid_d = 1'b1;
            win_id_d    = GW'(i);
         end
      end
   end
`else
   logic [GW-1:0]     rr_q;
   logic [GW-1:0]     rr_d;

   function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return GW'(s);
   endfunction

   // Round-robin: scan offsets high to low from rr_q so the nearest requester wins.
   always_comb begin
      win_valid_d = 1'b0;
      win_id_d    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[rr_index(rr_q, i)]) begin
            win_valid_d = 1'b1;
            win_id_d    = rr_index(rr_q, i);
         end
      end
      rr_d = (win_id_d == GW'(NREQ - 1)) ? '0 : win_id_d + GW'(1);
   end

   // Pointer advances past the winner on every grant taken from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else if (state_q == S_IDLE && win_valid_d) begin
         rr_q <= rr_d;
      end
   end
`endif

   // Winner's payload and the strobe/ack decodes used by the FSM.
   always_comb begin
      win_addr_d = req_addr[int'(win_id_d) * AW +: AW];
      win_data_d = req_data[int'(win_id_d) * N +: N];
      load_en_d  = '0;
      for (int r = 0; r < NREG; r++) begin
         load_en_d[r] = (win_addr_d == AW'(r));
      end
      ack_d = '0;
      for (int j = 0; j < NREQ; j++) begin
         ack_d[j] = (gnt_id_q == GW'(j));
      end
      addr_oor_d = (int'(addr_q) >= NREG);
   end

   // Transaction FSM; every output is a register so req never reaches an output combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         load_data_q <= '0;
         gnt_id_q    <= '0;
         load_en_q   <= '0;
         ack_q       <= '0;
         addr_err_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         load_en_q  <= '0;
         ack_q      <= '0;
         addr_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (win_valid_d) begin
                  state_q     <= S_LOAD;
                  addr_q      <= win_addr_d;
                  load_data_q <= win_data_d;
                  gnt_id_q    <= win_id_d;
                  load_en_q   <= load_en_d;
                  busy_q      <= 1'b1;
               end
            end
            S_LOAD: begin
               state_q    <= S_ACK;
               ack_q      <= ack_d;
               addr_err_q <= addr_oor_d;
            end
            S_ACK: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign addr_err  = addr_err_q;
   assign load_en   = load_en_q;
   assign load_data = load_data_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = busy_q;

endmodule
